// File: rtl/instr_controller_pkg.sv
// Shared types and encodings for the instruction controller and its decoder.
package cpu_pkg;

  typedef enum logic [2:0] {
    StWait,
    StDecode,
    StWriteImm,
    StGetA,
    StGetB,
    StExec,
    StWriteReg
  } state_e;

  localparam logic [2:0] OpcMov = 3'b110;
  localparam logic [2:0] OpcAlu = 3'b101;

  localparam logic [1:0] OpMovReg = 2'b00;
  localparam logic [1:0] OpMovImm = 2'b10;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluCmp = 2'b01;
  localparam logic [1:0] AluAnd = 2'b10;
  localparam logic [1:0] AluMvn = 2'b11;

  localparam logic [1:0] ShNone = 2'b00;
  localparam logic [1:0] ShLsl  = 2'b01;
  localparam logic [1:0] ShLsr  = 2'b10;
  localparam logic [1:0] ShAsr  = 2'b11;

  function automatic logic [15:0] sign_ext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/instr_controller_if.sv
// Host/datapath-facing bundle of the instruction controller.
interface instr_controller_if;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] datapath_in;

  modport master (
    input  in, load, s,
    output w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
    output asel, bsel, shift, ALUop, datapath_in
  );

  modport slave (
    output in, load, s,
    input  w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
    input  asel, bsel, shift, ALUop, datapath_in
  );
endinterface

// File: rtl/instr_decoder.sv
// Combinational field split of the instruction register plus imm8 sign extension.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [2:0]  opcode_o,
  output logic [1:0]  op_o,
  output logic [2:0]  rn_o,
  output logic [2:0]  rd_o,
  output logic [1:0]  sh_o,
  output logic [2:0]  rm_o,
  output logic [15:0] imm_ext_o
);
  assign opcode_o  = ir_i[15:13];
  assign op_o      = ir_i[12:11];
  assign rn_o      = ir_i[10:8];
  assign rd_o      = ir_i[7:5];
  assign sh_o      = ir_i[4:3];
  assign rm_o      = ir_i[2:0];
  assign imm_ext_o = sign_ext8(ir_i[7:0]);
endmodule

// File: rtl/instr_controller.sv
// Multi-cycle control unit: IR, Moore FSM and datapath control decode.
module instr_controller
  import cpu_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  instr_controller_if.master bus
);
  logic [15:0] ir_q;
  state_e      state_q, state_d;

  logic [2:0]  opcode, rn, rd, rm;
  logic [1:0]  op, sh;
  logic [15:0] imm_ext;

  instr_decoder u_dec (
    .ir_i     (ir_q),
    .opcode_o (opcode),
    .op_o     (op),
    .rn_o     (rn),
    .rd_o     (rd),
    .sh_o     (sh),
    .rm_o     (rm),
    .imm_ext_o(imm_ext)
  );

  logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;
  assign is_mov_imm = (opcode == OpcMov) && (op == OpMovImm);
  assign is_mov_reg = (opcode == OpcMov) && (op == OpMovReg);
  assign is_alu     = (opcode == OpcAlu);
  assign is_cmp     = is_alu && (op == AluCmp);
  assign is_mvn     = is_alu && (op == AluMvn);

  // IR only moves in WAIT so the fields stay stable for the whole instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWait;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StWait && bus.load) ir_q <= bus.in;
    end
  end

  assign bus.datapath_in = imm_ext;

  always_comb begin
    state_d      = state_q;
    bus.w        = 1'b0;
    bus.readnum  = 3'd0;
    bus.writenum = 3'd0;
    bus.write    = 1'b0;
    bus.vsel     = 1'b0;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    bus.shift    = ShNone;
    bus.ALUop    = AluAdd;

    unique case (state_q)
      StWait: begin
        bus.w = 1'b1;
        if (bus.s) state_d = StDecode;
      end
      StDecode: begin
        if (is_mov_imm)                state_d = StWriteImm;
        else if (is_mov_reg || is_mvn) state_d = StGetB;
        else if (is_alu)               state_d = StGetA;
        else                           state_d = StWait;
      end
      StWriteImm: begin
        bus.writenum = rn;
        bus.vsel     = 1'b1;
        bus.write    = 1'b1;
        state_d      = StWait;
      end
      StGetA: begin
        bus.readnum = rn;
        bus.loada   = 1'b1;
        state_d     = StGetB;
      end
      StGetB: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
        state_d     = StExec;
      end
      StExec: begin
        bus.shift = sh;
        // MOV reg and MVN ignore A by forcing a zero operand.
        bus.asel  = is_mov_reg || is_mvn;
        bus.ALUop = is_mov_reg ? AluAdd : op;
        bus.loadc = !is_cmp;
        bus.loads = is_cmp;
        state_d   = is_cmp ? StWait : StWriteReg;
      end
      StWriteReg: begin
        bus.writenum = rd;
        bus.write    = 1'b1;
        state_d      = StWait;
      end
      default: state_d = StWait;
    endcase
  end
endmodule

// File: tb/tb_instr_controller.sv
// Self-checking bench: controller driving a small behavioural register/ALU datapath.
module tb_instr_controller;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_controller_if dut_if ();

  instr_controller dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dut_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural datapath
  logic [15:0] regs [8];
  logic [15:0] ra, rb, rc;
  logic        z;
  logic        model_clr;

  function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] sh);
    case (sh)
      2'b01:   return {v[14:0], 1'b0};
      2'b10:   return {1'b0, v[15:1]};
      2'b11:   return {v[15], v[15:1]};
      default: return v;
    endcase
  endfunction

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return ~b;
    endcase
  endfunction

  logic [15:0] alu_out;
  assign alu_out = alu_f(dut_if.asel ? 16'h0 : ra,
                         dut_if.bsel ? {11'b0, dut_if.datapath_in[4:0]} : shf(rb, dut_if.shift),
                         dut_if.ALUop);

  always @(posedge clk) begin
    if (model_clr) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'h0;
      ra <= 16'h0; rb <= 16'h0; rc <= 16'h0; z <= 1'b0;
    end else begin
      if (dut_if.write) regs[dut_if.writenum] <= dut_if.vsel ? dut_if.datapath_in : rc;
      if (dut_if.loada) ra <= regs[dut_if.readnum];
      if (dut_if.loadb) rb <= regs[dut_if.readnum];
      if (dut_if.loadc) rc <= alu_out;
      if (dut_if.loads) z <= (alu_out == 16'h0);
    end
  end

  // Observations gathered while an instruction runs
  int          n_wr, n_lc, n_ls;
  logic        any_en;
  logic [2:0]  wr_num;
  logic        wr_vsel;
  logic [15:0] wr_dp;
  logic        ex_asel, ex_loadc, ex_loads;
  logic [1:0]  ex_shift, ex_aluop;

  task automatic sample();
    if (dut_if.write) begin
      n_wr++;
      wr_num  = dut_if.writenum;
      wr_vsel = dut_if.vsel;
      wr_dp   = dut_if.datapath_in;
    end
    if (dut_if.loadc) n_lc++;
    if (dut_if.loads) n_ls++;
    if (dut_if.loadc || dut_if.loads) begin
      ex_asel  = dut_if.asel;
      ex_shift = dut_if.shift;
      ex_aluop = dut_if.ALUop;
      ex_loadc = dut_if.loadc;
      ex_loads = dut_if.loads;
    end
    any_en = any_en | (|{dut_if.write, dut_if.vsel, dut_if.loada, dut_if.loadb, dut_if.loadc,
                         dut_if.loads, dut_if.asel, dut_if.bsel, dut_if.readnum,
                         dut_if.writenum, dut_if.shift, dut_if.ALUop});
  endtask

  // Issue one instruction; count edges from the s-sampling edge until w is back.
  task automatic issue(input logic [15:0] instr, input bit hold_s, input bit disturb,
                       output int edges);
    edges = 0; n_wr = 0; n_lc = 0; n_ls = 0; any_en = 1'b0;
    wr_num = '0; wr_vsel = 1'b0; wr_dp = '0;
    ex_asel = 1'b0; ex_loadc = 1'b0; ex_loads = 1'b0; ex_shift = '0; ex_aluop = '0;
    @(negedge clk);
    dut_if.in = instr; dut_if.load = 1'b1; dut_if.s = 1'b1;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (disturb && (edges == 2 || edges == 3)) begin
        dut_if.in = 16'hD0FF; dut_if.load = 1'b1; dut_if.s = 1'b1;
      end else begin
        dut_if.load = 1'b0; dut_if.s = hold_s;
      end
      if (!dut_if.w) sample();
    end while (!dut_if.w && edges < 20);
  endtask

  typedef struct {
    logic [15:0] instr;
    int          edges;
    int          wr;
    int          lc;
    int          ls;
    int          rg;
    logic [15:0] val;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int e;
    int wcnt;

    vecs[0] = '{16'hD007, 3, 1, 0, 0, 0, 16'h0007};  // MOV R0,#7
    vecs[1] = '{16'hD1FE, 3, 1, 0, 0, 1, 16'hFFFE};  // MOV R1,#-2
    vecs[2] = '{16'hA148, 6, 1, 1, 0, 2, 16'h000C};  // ADD R2,R1,R0 LSL#1
    vecs[3] = '{16'hA800, 5, 0, 0, 1, 0, 16'h0007};  // CMP R0,R0
    vecs[4] = '{16'hC071, 5, 1, 1, 0, 3, 16'h7FFF};  // MOV R3,R1 LSR
    vecs[5] = '{16'hB880, 5, 1, 1, 0, 4, 16'hFFF8};  // MVN R4,R0
    vecs[6] = '{16'hE000, 2, 0, 0, 0, 0, 16'h0007};  // unsupported
    vecs[7] = '{16'hB1A3, 6, 1, 1, 0, 5, 16'h7FFE};  // AND R5,R1,R3
    vecs[8] = '{16'hD800, 2, 0, 0, 0, 1, 16'hFFFE};  // unsupported op under 110

    dut_if.in = 16'h0; dut_if.load = 1'b0; dut_if.s = 1'b0;
    rst_n = 1'b0;
    model_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_w", dut_if.w, 1);
    chk("reset_ctrl", {dut_if.readnum, dut_if.writenum, dut_if.write, dut_if.vsel,
                       dut_if.loada, dut_if.loadb, dut_if.loadc, dut_if.loads, dut_if.asel,
                       dut_if.bsel, dut_if.shift, dut_if.ALUop}, 0);
    chk("reset_dp_in", dut_if.datapath_in, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clr = 1'b0;

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].instr, 1'b0, 1'b0, e);
      chk($sformatf("edges_%h", vecs[i].instr), e, vecs[i].edges);
      chk($sformatf("writes_%h", vecs[i].instr), n_wr, vecs[i].wr);
      chk($sformatf("loadc_%h", vecs[i].instr), n_lc, vecs[i].lc);
      chk($sformatf("loads_%h", vecs[i].instr), n_ls, vecs[i].ls);
      chk($sformatf("reg_%h", vecs[i].instr), regs[vecs[i].rg], vecs[i].val);
      case (vecs[i].instr)
        16'hD007: begin
          chk("movimm_writenum", wr_num, 0);
          chk("movimm_vsel", wr_vsel, 1);
          chk("movimm_dp_in", wr_dp, 16'h0007);
        end
        16'hD1FE: begin
          chk("movneg_writenum", wr_num, 1);
          chk("movneg_dp_in", wr_dp, 16'hFFFE);
        end
        16'hA148: begin
          chk("add_aluop", ex_aluop, 0);
          chk("add_asel", ex_asel, 0);
          chk("add_shift", ex_shift, 1);
          chk("add_writenum", wr_num, 2);
          chk("add_vsel", wr_vsel, 0);
        end
        16'hA800: begin
          chk("cmp_aluop", ex_aluop, 1);
          chk("cmp_loads", ex_loads, 1);
          chk("cmp_loadc", ex_loadc, 0);
          chk("cmp_z", z, 1);
        end
        16'hC071: begin
          chk("movreg_asel", ex_asel, 1);
          chk("movreg_shift", ex_shift, 2);
          chk("movreg_aluop", ex_aluop, 0);
        end
        16'hB880: begin
          chk("mvn_aluop", ex_aluop, 3);
          chk("mvn_asel", ex_asel, 1);
        end
        16'hE000, 16'hD800: chk($sformatf("nop_enables_%h", vecs[i].instr), any_en, 0);
        default: ;
      endcase
    end

    // load/s toggled during ADD R6,R1,R0 must not disturb it
    issue(16'hA1C0, 1'b0, 1'b1, e);
    chk("disturb_edges", e, 6);
    chk("disturb_writes", n_wr, 1);
    chk("disturb_ir_stable", wr_dp, 16'hFFC0);
    chk("disturb_result", regs[6], 16'h0005);

    // s held high: next instruction starts on the first edge w=1 is seen
    issue(16'hD705, 1'b1, 1'b0, e);
    chk("hold_edges", e, 3);
    @(posedge clk);
    #1;
    chk("hold_restart_w", dut_if.w, 0);
    @(negedge clk);
    dut_if.s = 1'b0;
    for (int k = 0; k < 10 && !dut_if.w; k++) @(negedge clk);
    chk("hold_done_w", dut_if.w, 1);
    chk("hold_r7", regs[7], 16'h0005);

    // Reset in the middle of ADD R5,R1,R0
    @(negedge clk);
    dut_if.in = 16'hA1A0; dut_if.load = 1'b1; dut_if.s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dut_if.load = 1'b0; dut_if.s = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("abort_in_exec", dut_if.loadc, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_w", dut_if.w, 1);
    chk("abort_write", dut_if.write, 0);
    chk("abort_loadc", dut_if.loadc, 0);
    chk("abort_ir_zero", dut_if.datapath_in, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wcnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (dut_if.write || dut_if.loadc) wcnt++;
    end
    chk("abort_no_pulse", wcnt, 0);
    chk("abort_r5_kept", regs[5], 16'h7FFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
